sync_fifo_thresh: RTL and testbench



---
 rtl/sync_fifo_thresh.sv | 104 ++++++++++
 tb/tb_sync_fifo_thresh.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thresh.sv
// Single-clock first-word-fall-through FIFO with occupancy count and almost-full/almost-empty flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and their err_clr input.
module sync_fifo_thresh #(
  parameter int unsigned DSIZE         = 8,
  parameter int unsigned ASIZE         = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ASIZE) - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
`ifdef SYNC_FIFO_ERR_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [ASIZE:0]   count
);

  localparam int unsigned   DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] PtrOne    = (ASIZE + 1)'(1);
  localparam logic [ASIZE:0] AfullLvl  = (ASIZE + 1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AemptyLvl = (ASIZE + 1)'(AEMPTY_THRESH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             wen, ren;

  // Flags depend only on registered pointers/count, never on winc/rinc.
  always_comb begin
    rempty        = (wptr_q == rptr_q);
    wfull         = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) && (wptr_q[ASIZE] != rptr_q[ASIZE]);
    walmost_full  = (count_q >= AfullLvl);
    ralmost_empty = (count_q <= AemptyLvl);
    count         = count_q;
    rdata         = rempty ? '0 : mem_q[rptr_q[ASIZE-1:0]];
  end

  always_comb begin
    wen     = winc & ~wfull;
    ren     = rinc & ~rempty;
    wptr_d  = wen ? wptr_q + PtrOne : wptr_q;
    rptr_d  = ren ? rptr_q + PtrOne : rptr_q;
    count_d = count_q;
    unique case ({wen, ren})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wen && !reset) begin
      mem_q[wptr_q[ASIZE-1:0]] <= wdata;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the same cycle as err_clr wins so it is never lost.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | (winc & wfull);
    unf_d = (unf_q & ~err_clr) | (rinc & rempty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh with DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.
// Builds with or without SYNC_FIFO_ERR_EN.
module tb_sync_fifo_thresh;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdata;
  logic       winc;
  logic       wfull;
  logic       walmost_full;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
  logic       ralmost_empty;
  logic [2:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
`endif

  int total = 0;
  int bad   = 0;

  sync_fifo_thresh #(
    .DSIZE        (8),
    .ASIZE        (2),
    .AFULL_THRESH (3),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wdata        (wdata),
    .winc         (winc),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    winc = 1'b1; wdata = d; tick(); winc = 1'b0;
  endtask

  task automatic pop();
    rinc = 1'b1; tick(); rinc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; winc = 1'b1; rinc = 1'b0; wdata = 8'hFF;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0; winc = 1'b0;
    total++;
    if (count !== 3'd0) begin
      $display("FAIL reset_count got=%0d want=0", count); bad++;
    end
    total++;
    if ({wfull, walmost_full, rempty, ralmost_empty} !== 4'b0011) begin
      $display("FAIL reset_flags got=%b want=0011", {wfull, walmost_full, rempty, ralmost_empty});
      bad++;
    end
    total++;
    if (rdata !== 8'h00) begin
      $display("FAIL reset_rdata got=%h want=00", rdata); bad++;
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if ({overflow, underflow} !== 2'b00) begin
      $display("FAIL reset_err got=%b want=00", {overflow, underflow}); bad++;
    end
`endif
  endtask

  task automatic test_fill();
    logic [7:0] vals  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] flags [4] = '{4'b0001, 4'b0000, 4'b0100, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      total++;
      if (count !== 3'(i + 1)) begin
        $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); bad++;
      end
      total++;
      if ({wfull, walmost_full, rempty, ralmost_empty} !== flags[i]) begin
        $display("FAIL fill_flags[%0d] got=%b want=%b", i,
                 {wfull, walmost_full, rempty, ralmost_empty}, flags[i]);
        bad++;
      end
      total++;
      if (rdata !== 8'h11) begin
        $display("FAIL fill_rdata[%0d] got=%h want=11", i, rdata); bad++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] heads [4] = '{8'h22, 8'h33, 8'h44, 8'h00};
    logic [3:0] flags [4] = '{4'b0100, 4'b0000, 4'b0001, 4'b0011};
    winc = 1'b1; wdata = 8'h55;
    tick(); tick();
    winc = 1'b0;
    total++;
    if (count !== 3'd4 || rdata !== 8'h11) begin
      $display("FAIL ovf_hold got count=%0d rdata=%h want count=4 rdata=11", count, rdata); bad++;
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_flag got=%b want=1", overflow); bad++;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      pop();
      total++;
      if (rdata !== heads[i] || count !== 3'(3 - i)) begin
        $display("FAIL drain[%0d] got rdata=%h count=%0d want rdata=%h count=%0d",
                 i, rdata, count, heads[i], 3 - i);
        bad++;
      end
      total++;
      if ({wfull, walmost_full, rempty, ralmost_empty} !== flags[i]) begin
        $display("FAIL drain_flags[%0d] got=%b want=%b", i,
                 {wfull, walmost_full, rempty, ralmost_empty}, flags[i]);
        bad++;
      end
    end
    pop();
    total++;
    if (count !== 3'd0 || rempty !== 1'b1) begin
      $display("FAIL underrun got count=%0d rempty=%b want count=0 rempty=1", count, rempty);
      bad++;
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if ({overflow, underflow} !== 2'b11) begin
      $display("FAIL err_sticky got=%b want=11", {overflow, underflow}); bad++;
    end
    err_clr = 1'b1; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    total++;
    if ({overflow, underflow} !== 2'b01) begin
      $display("FAIL err_clr_collide got=%b want=01", {overflow, underflow}); bad++;
    end
    tick();
    err_clr = 1'b0;
    total++;
    if ({overflow, underflow} !== 2'b00) begin
      $display("FAIL err_clr got=%b want=00", {overflow, underflow}); bad++;
    end
`endif
  endtask

  task automatic test_empty_simul();
    winc = 1'b1; rinc = 1'b1; wdata = 8'hA5;
    tick();
    total++;
    if (count !== 3'd1 || rdata !== 8'hA5 || rempty !== 1'b0) begin
      $display("FAIL empty_rw got count=%0d rdata=%h rempty=%b want 1 a5 0", count, rdata, rempty);
      bad++;
    end
    wdata = 8'h5A;
    tick();
    winc = 1'b0; rinc = 1'b0;
    total++;
    if (count !== 3'd1 || rdata !== 8'h5A) begin
      $display("FAIL single_rw got count=%0d rdata=%h want 1 5a", count, rdata); bad++;
    end
    pop();
  endtask

  task automatic test_full_simul();
    logic [7:0] heads [4] = '{8'h03, 8'h04, 8'h00, 8'h00};
    for (int i = 1; i <= 4; i++) push(8'(i));
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    tick();
    winc = 1'b0; rinc = 1'b0;
    total++;
    if (count !== 3'd3 || wfull !== 1'b0 || rdata !== 8'h02) begin
      $display("FAIL full_rw got count=%0d wfull=%b rdata=%h want 3 0 02", count, wfull, rdata);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      pop();
      total++;
      if (rdata !== heads[i]) begin
        $display("FAIL full_rw_drain[%0d] got=%h want=%h", i, rdata, heads[i]); bad++;
      end
    end
    total++;
    if (rempty !== 1'b1) begin
      $display("FAIL full_rw_empty got=%b want=1", rempty); bad++;
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    push(8'h00);
    push(8'h01);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (rdata !== 8'(i)) begin
        $display("FAIL stream_data[%0d] got=%h want=%h", i, rdata, 8'(i)); bad++;
      end
      winc = 1'b1; rinc = 1'b1; wdata = 8'(i + 2);
      tick();
      if (count !== 3'd2 || {wfull, walmost_full, rempty, ralmost_empty} !== 4'b0000) errs++;
    end
    winc = 1'b0; rinc = 1'b0;
    total++;
    if (errs != 0) begin
      $display("FAIL stream_state got=%0d bad cycles want=0", errs); bad++;
    end
    for (int i = 18; i < 20; i++) begin
      total++;
      if (rdata !== 8'(i)) begin
        $display("FAIL stream_tail[%0d] got=%h want=%h", i, rdata, 8'(i)); bad++;
      end
      pop();
    end
    total++;
    if (rempty !== 1'b1 || rdata !== 8'h00) begin
      $display("FAIL stream_end got rempty=%b rdata=%h want 1 00", rempty, rdata); bad++;
    end
  endtask

  task automatic test_reset_mid();
    push(8'h61); push(8'h62); push(8'h63);
    reset = 1'b1; winc = 1'b1; wdata = 8'h77;
    tick();
    reset = 1'b0; winc = 1'b0;
    total++;
    if (count !== 3'd0 || rempty !== 1'b1 || rdata !== 8'h00) begin
      $display("FAIL mid_reset got count=%0d rempty=%b rdata=%h want 0 1 00", count, rempty, rdata);
      bad++;
    end
    push(8'h88);
    total++;
    if (count !== 3'd1 || rdata !== 8'h88) begin
      $display("FAIL post_reset got count=%0d rdata=%h want 1 88", count, rdata); bad++;
    end
  endtask

  initial begin
    reset = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_empty_simul();
    test_full_simul();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
